// File: rtl/apb_ram_bridge.sv
// APB slave that turns each APB transfer into a single access on the RAM request port.
// Optional busy timeout: define APB_RAM_BRIDGE_TIMEOUT_EN.
module apb_ram_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_DEPTH      = 1024,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_busy
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(RAM_DEPTH);

  state_t state;
  logic   write_q;
  logic   setup;
  logic   addr_err;
  logic   timeout;

  assign setup    = PSEL && !PENABLE;
  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR[ADDR_WIDTH-1:2] >= DEPTH_WORDS);

`ifdef APB_RAM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BUSY = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tcount;

  assign timeout = ram_busy && (tcount == LAST_BUSY);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef APB_RAM_BRIDGE_TIMEOUT_EN
      tcount    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          // An access phase without a setup phase is ignored here.
          if (setup) begin
            ram_addr  <= PADDR;
            ram_wdata <= PWDATA;
            write_q   <= PWRITE;
            if (addr_err) begin
              state   <= ERR;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
            end else begin
              state   <= REQ;
              ram_ren <= !PWRITE;
              ram_wen <= PWRITE;
`ifdef APB_RAM_BRIDGE_TIMEOUT_EN
              tcount  <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (timeout) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            PRDATA  <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= 1'b1;
            state   <= ERR;
          end else if (!ram_busy) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            // An abandoned transfer still completes on the RAM side but returns nothing.
            if (PSEL) begin
              PRDATA <= write_q ? '0 : ram_rdata;
              PREADY <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= IDLE;
            end
          end else begin
`ifdef APB_RAM_BRIDGE_TIMEOUT_EN
            tcount <= tcount + 1'b1;
`endif
          end
        end
        DONE, ERR: begin
          PRDATA  <= '0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
